// File: rtl/picorv32_trace_pkg.sv
// Shared definitions for the trace elastic buffer.
//   TRACE_W      : trace word width (flags + payload)
//   tb_state_e   : buffer sequencing state (run / flush / done)
//   trace_flags  : helper to extract the flag nibble of a trace word
package picorv32_trace_pkg;
  localparam int TRACE_W   = 36;
  localparam int PAYLOAD_W = 32;
  localparam int FLAG_W    = 4;
  localparam int FLAG_LSB  = PAYLOAD_W;

  typedef enum logic [1:0] {
    TB_RUN   = 2'd0,
    TB_FLUSH = 2'd1,
    TB_DONE  = 2'd2
  } tb_state_e;

  function automatic logic [FLAG_W-1:0] trace_flags(input logic [TRACE_W-1:0] w);
    return w[FLAG_LSB +: FLAG_W];
  endfunction
endpackage

// File: rtl/picorv32_trace_fifo_core.sv
// Storage and occupancy tracking for the trace buffer.
//   clk, resetn : clock, async active-low reset (pointers only, array not reset)
//   i_push      : write i_data at the tail (caller guarantees room or a same-cycle pop)
//   i_pop       : retire the head (caller guarantees non-empty)
//   o_data      : head entry, fall-through from registered state
//   o_full/o_empty/o_level : occupancy, level in 0..DEPTH
module picorv32_trace_fifo_core #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 36
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Push into a full buffer with a simultaneous pop overwrites the slot
  // being read; the old head is consumed at this same edge, so that is safe.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Modular difference of the wrap-extended pointers is exactly 0..DEPTH.
  assign o_level = r_wr_ptr - r_rd_ptr;
endmodule

// File: rtl/picorv32_trace_buf.sv
// Elastic buffer between the core trace port and the trace consumer.
//   clk, resetn             : clock, async active-low reset
//   trace_valid/trace_data  : trace beats, no back-pressure to the source
//   trap                    : first observation in RUN starts an orderly flush
//   out_valid/out_ready/out_data : ready/valid consumer side, fall-through head
//   level                   : occupancy 0..DEPTH
//   dropped / overflow      : saturating drop count / sticky drop flag
//   done                    : flush complete, held until reset
module picorv32_trace_buf
  import picorv32_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = TRACE_W,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   trace_valid,
  input  logic [DATA_W-1:0]      trace_data,
  input  logic                   trap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       dropped,
  output logic                   overflow,
  output logic                   done
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  tb_state_e r_state, w_state_nxt;
  logic      w_accept, w_full, w_empty, w_push, w_pop, w_drop;
  logic [CNT_W-1:0] r_dropped;
  logic             r_overflow;

  assign w_pop  = out_valid & out_ready;
  // A pop in the same cycle makes room, so a full buffer still accepts.
  assign w_push = trace_valid & w_accept & (~w_full | w_pop);
  assign w_drop = trace_valid & w_accept & w_full & ~w_pop;

  picorv32_trace_fifo_core #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_core (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (trace_data),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= TB_RUN;
    else         r_state <= w_state_nxt;
  end

  // Next state: trap is only looked at in RUN, so a later deassert is moot.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TB_RUN:   if (trap) w_state_nxt = TB_FLUSH;
      TB_FLUSH: if (level == LW'(0) || (level == LW'(1) && w_pop))
                  w_state_nxt = TB_DONE;
      TB_DONE:  w_state_nxt = TB_DONE;
      default:  w_state_nxt = TB_RUN;
    endcase
  end

  // Outputs from current state
  always_comb begin
    w_accept = (r_state == TB_RUN);
    done     = (r_state == TB_DONE);
  end

  assign out_valid = ~w_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dropped  <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_dropped != '1) r_dropped <= r_dropped + CNT_ONE;
    end
  end

  assign dropped  = r_dropped;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_picorv32_trace_buf.sv
module tb_picorv32_trace_buf;
  localparam int DEPTH = 16;
  localparam int DW    = 36;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          trace_valid = 1'b0;
  logic [DW-1:0] trace_data = '0;
  logic          trap = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [4:0]    level;
  logic [15:0]   dropped;
  logic          overflow, done;

  // Second instance with a narrow drop counter, fed the same stimulus.
  logic          s_out_valid, s_overflow, s_done;
  logic [DW-1:0] s_out_data;
  logic [4:0]    s_level;
  logic [3:0]    s_dropped;

  picorv32_trace_buf #(.DEPTH(DEPTH), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .trace_valid(trace_valid), .trace_data(trace_data),
    .trap(trap), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .dropped(dropped), .overflow(overflow), .done(done));

  picorv32_trace_buf #(.DEPTH(DEPTH), .DATA_W(DW), .CNT_W(4)) dut_s (
    .clk(clk), .resetn(resetn), .trace_valid(trace_valid), .trace_data(trace_data),
    .trap(trap), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .level(s_level), .dropped(s_dropped), .overflow(s_overflow), .done(s_done));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected words are queued when the model accepts a beat.
  logic [DW-1:0] exp_q[$];
  int m_level, m_drop, m_drop_s, m_state;  // state 0=RUN 1=FLUSH 2=DONE
  bit m_pop, m_full, m_acc, m_push, m_drp;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_level  <= 0;
      m_drop   <= 0;
      m_drop_s <= 0;
      m_state  <= 0;
      exp_q.delete();
    end else begin
      m_pop  = (m_level != 0) && out_ready;
      m_full = (m_level == DEPTH);
      m_acc  = (m_state == 0);
      m_push = trace_valid && m_acc && (!m_full || m_pop);
      m_drp  = trace_valid && m_acc && m_full && !m_pop;
      if (m_push) exp_q.push_back(trace_data);
      m_level <= m_level + int'(m_push) - int'(m_pop);
      if (m_drp) begin
        m_drop <= m_drop + 1;
        if (m_drop_s < 15) m_drop_s <= m_drop_s + 1;
      end
      if (m_state == 0 && trap) m_state <= 1;
      else if (m_state == 1 && (m_level == 0 || (m_level == 1 && m_pop))) m_state <= 2;
    end
  end

  // Monitor: mid-cycle sampling; a handshake seen here retires at the next edge.
  always @(negedge clk) begin
    if (resetn) begin
      chk("level", 64'(level), 64'(m_level));
      chk("out_valid", 64'(out_valid), 64'(m_level != 0));
      chk("done", 64'(done), 64'(m_state == 2));
      chk("dropped", 64'(dropped), 64'(m_drop));
      chk("dropped_sat", 64'(s_dropped), 64'(m_drop_s));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL out_data: got 0x%0h expected none (queue empty) @%0t", out_data, $time);
        end else begin
          chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    trace_valid = 1'b1;
    trace_data  = d;
    tick();
    trace_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dropped", 64'(dropped), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    tick();
    resetn = 1'b1;

    // Streaming with an always-ready consumer
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      trace_valid = 1'b1;
      trace_data  = DW'(i);
      tick();
      chk("stream_level_le1", 64'(level <= 5'd1), 64'd1);
    end
    trace_valid = 1'b0;
    tick(); tick();
    chk("stream_level_end", 64'(level), 64'd0);
    chk("stream_dropped", 64'(dropped), 64'd0);

    // Fill and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) beat(DW'(i));
    chk("fill_level", 64'(level), 64'd16);
    chk("fill_dropped", 64'(dropped), 64'd4);
    chk("fill_overflow", 64'(overflow), 64'd1);
    chk("fill_dropped_s", 64'(s_dropped), 64'd4);

    // Full with simultaneous pop: beat accepted, head 0 retired
    out_ready = 1'b1;
    beat(36'hA_DEAD_BEEF);
    out_ready = 1'b0;
    chk("fullpop_level", 64'(level), 64'd16);
    chk("fullpop_dropped", 64'(dropped), 64'd4);

    // Saturation of the narrow counter
    for (int i = 0; i < 20; i++) beat(DW'(100 + i));
    chk("sat_dropped_s", 64'(s_dropped), 64'd15);
    chk("sat_dropped", 64'(dropped), 64'd24);
    for (int i = 0; i < 5; i++) beat(DW'(200 + i));
    chk("sat_hold_s", 64'(s_dropped), 64'd15);
    chk("sat_dropped2", 64'(dropped), 64'd29);

    // Drain: expect 1..15 then A_DEAD_BEEF (checked by the monitor)
    out_ready = 1'b1;
    for (int k = 0; k < 40 && level != 5'd0; k++) tick();
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_q_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_overflow_sticky", 64'(overflow), 64'd1);

    // Trap flush
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) beat(DW'(36'h200 + i));
    trap = 1'b1;
    beat(36'h1);
    trap = 1'b0;
    for (int i = 0; i < 3; i++) beat(DW'(36'h300 + i));
    chk("trap_level", 64'(level), 64'd6);
    chk("trap_dropped", 64'(dropped), 64'd29);
    chk("trap_done_early", 64'(done), 64'd0);
    out_ready = 1'b1;
    repeat (6) tick();
    out_ready = 1'b0;
    chk("flush_done", 64'(done), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_level", 64'(level), 64'd0);
    beat(36'h999);
    chk("done_ignore_level", 64'(level), 64'd0);
    chk("done_ignore_dropped", 64'(dropped), 64'd29);
    chk("done_hold", 64'(done), 64'd1);

    // Asynchronous reset in the middle of a flush
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rst2_done", 64'(done), 64'd0);
    for (int i = 0; i < 6; i++) beat(DW'(36'h400 + i));
    trap = 1'b1;
    beat(36'h7);
    trap = 1'b0;
    chk("preflush_level", 64'(level), 64'd7);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_dropped", 64'(dropped), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    #2;
    resetn = 1'b1;
    tick(); tick();
    chk("post_rst_level", 64'(level), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    n_chk++; n_err++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "timeout");
  end
endmodule
